// File: rtl/byte_serial_add_ctrl_if.sv
// byte_serial_add_ctrl_if
// Groups the signals of the byte-serial addition sequencer:
//   - command: start, cin, done, cout, overflow
//   - input stream: in_valid/in_ready with the a_byte/b_byte operand pair
//   - adder port: add_x/add_y/add_c0 out to the 8-bit adder, add_s/add_c8 back
//   - output stream: out_valid/out_ready with sum_byte and out_last
// Modports:
//   slave  - the sequencer itself
//   master - the surrounding logic (control, byte source, adder, byte sink)
interface byte_serial_add_ctrl_if;
    logic       start;
    logic       cin;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_byte;
    logic [7:0] b_byte;
    logic [7:0] add_x;
    logic [7:0] add_y;
    logic       add_c0;
    logic [7:0] add_s;
    logic       add_c8;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum_byte;
    logic       out_last;
    logic       done;
    logic       cout;
    logic       overflow;

    modport slave (
        input  start, cin, in_valid, a_byte, b_byte, add_s, add_c8, out_ready,
        output in_ready, add_x, add_y, add_c0, out_valid, sum_byte, out_last,
               done, cout, overflow
    );

    modport master (
        output start, cin, in_valid, a_byte, b_byte, add_s, add_c8, out_ready,
        input  in_ready, add_x, add_y, add_c0, out_valid, sum_byte, out_last,
               done, cout, overflow
    );
endinterface

// File: rtl/byte_serial_add_ctrl.sv
// byte_serial_add_ctrl
// Sequences an NBYTES-wide addition through an external 8-bit adder, one
// byte pair per accepted input beat, least-significant byte first. The
// carry is chained between bytes in carry_q. Result bytes leave through a
// single-entry valid/ready output register; after the last byte drains,
// done pulses once and cout (and overflow) hold until the next start.
//
// Parameters:
//   NBYTES - operand length in bytes (1..16)
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - byte_serial_add_ctrl_if.slave (command, streams, adder port)
// Build option:
//   SERIAL_ADD_OVF_EN - when defined, overflow reports signed overflow of
//                       the full-width sum; otherwise overflow is tied to 0.
module byte_serial_add_ctrl #(
    parameter int NBYTES = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    byte_serial_add_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       sum_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic             done_q;
    logic             cout_q;

    logic accept;
    logic out_hs;
    logic last_beat;

    // Adder sits directly in the input path; only the carry is registered.
    assign bus.add_x  = bus.a_byte;
    assign bus.add_y  = bus.b_byte;
    assign bus.add_c0 = carry_q;

    assign out_hs    = out_valid_q && bus.out_ready;
    // Accept a new pair whenever the output register is free or being
    // emptied this cycle, giving one byte per cycle at full throughput.
    assign bus.in_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign last_beat    = (cnt_q == CNT_W'(NBYTES - 1));

    assign bus.sum_byte  = sum_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.done      = done_q;
    assign bus.cout      = cout_q;

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;
    assign bus.overflow = ovf_q;
`else
    assign bus.overflow = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            cout_q      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        carry_q <= bus.cin;
                        cnt_q   <= '0;
                        cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                        ovf_q   <= 1'b0;
`endif
                        state_q <= RUN;
                    end
                end

                RUN: begin
                    if (accept) begin
                        // Reload wins over a simultaneous output handshake.
                        sum_q       <= bus.add_s;
                        carry_q     <= bus.add_c8;
                        out_valid_q <= 1'b1;
                        out_last_q  <= last_beat;
                        cnt_q       <= cnt_q + CNT_W'(1);
                        if (last_beat) begin
                            cout_q  <= bus.add_c8;
`ifdef SERIAL_ADD_OVF_EN
                            // Operands share a sign but the top result bit does not.
                            ovf_q   <= (bus.a_byte[7] == bus.b_byte[7]) &&
                                       (bus.add_s[7] != bus.a_byte[7]);
`endif
                            state_q <= DRAIN;
                        end
                    end else if (out_hs) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                end

                DRAIN: begin
                    if (out_hs) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/byte_serial_add_ctrl.md
# byte_serial_add_ctrl

- Sequencer for multi-byte additions on the 8-bit hybrid adder.
- Accepts two NBYTES-wide operands one byte pair at a time, least-significant byte first, over a valid/ready input stream.
- Drives the adder's X/Y/C0 inputs and captures its sum and C8 outputs, chaining carry between bytes through a register.
- Emits result bytes on a valid/ready output stream, then reports the final carry-out, plus signed overflow when that feature is compiled in.

## Interface

- NBYTES, 4, operand length in bytes; legal range 1–16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a new addition; sampled only in IDLE.
- cin  in  1  initial carry-in; sampled with start.
- in_valid  in  1  a_byte/b_byte valid.
- in_ready  out  1  block accepts a byte pair this cycle.
- a_byte  in  8  operand A byte.
- b_byte  in  8  operand B byte.
- add_x  out  8  to adder Xi.
- add_y  out  8  to adder Yi.
- add_c0  out  1  to adder C0.
- add_s  in  8  from adder Si.
- add_c8  in  1  from adder C8.
- out_valid  out  1  sum_byte valid.
- out_ready  in  1  downstream accepts sum_byte.
- sum_byte  out  8  result byte.
- out_last  out  1  qualifies the final result byte.
- done  out  1  one-cycle pulse at completion.
- cout  out  1  final carry-out; held until next start.
- overflow  out  1  signed overflow of the full-width sum; held until next start.

## Operation

- **Datapath**
  - add_x = a_byte, add_y = b_byte, add_c0 = carry_q; all combinational, with the adder in the input path.
- **States**
  - IDLE
    - in_ready = 0.
    - On start: carry_q <= cin, byte_cnt <= 0, cout <= 0, overflow <= 0; go to RUN.
  - RUN
    - in_ready = !out_valid || out_ready.
    - On accept (in_valid && in_ready): sum_byte <= add_s, carry_q <= add_c8, out_valid <= 1, out_last <= (byte_cnt == NBYTES-1), byte_cnt <= byte_cnt + 1.
    - When the accepted byte is the last: go to DRAIN; cout <= add_c8.
  - DRAIN
    - in_ready = 0.
    - When out_valid && out_ready: out_valid <= 0, out_last <= 0, done <= 1 for one cycle; go to IDLE.
- **Output register**
  - Without a new accept, out_valid clears when out_valid && out_ready.
  - sum_byte and out_last hold while out_valid && !out_ready.
- **Boundary conditions**
  - start outside IDLE is ignored.
  - in_valid in IDLE/DRAIN is not consumed.
  - Simultaneous output handshake and new input accept in RUN: the register reloads and out_valid stays 1 (full throughput).
  - NBYTES = 1: the first accept moves directly to DRAIN.
  - byte_cnt is ceil(log2(NBYTES+1)) bits and never wraps within an operation.
  - Reset mid-operation aborts: all state returns to reset values and partial results are discarded.

## Timing

- **Reset values:** state IDLE; in_ready 0, out_valid 0, out_last 0, sum_byte 0x00, done 0, cout 0, overflow 0, carry_q 0, byte_cnt 0.
  - add_x/add_y follow a_byte/b_byte combinationally.
  - add_c0 = carry_q = 0 at reset.
- **Latency:** a byte pair accepted at edge N has sum_byte/out_valid visible after edge N.
- **Start:** the first accept is possible in the cycle after start is sampled.
- **Throughput:** one byte pair per cycle when out_ready is held 1.
- **Completion:** done pulses in the cycle after the last byte's output handshake.
  - cout/overflow are stable from the last input accept onward.
  - Back-to-back operation: the next start is accepted no earlier than the cycle done is high, since the state is IDLE then.
- **Input handshake:** in_valid may not depend on in_ready; a_byte/b_byte must hold while in_valid && !in_ready.

## Configuration

- **SERIAL_ADD_OVF_EN**
  - Defined: on the last byte accept, overflow <= (a_byte[7] == b_byte[7]) && (add_s[7] != a_byte[7]).
  - Not defined: overflow is constant 0 and no overflow logic is synthesised.

## Test plan

- NBYTES=4, cin=0, A=0x000000FF, B=0x00000001 -> bytes 0x00,0x01,0x00,0x00; out_last on 4th only; cout=0; done pulses once.
- A=0xFFFFFFFF, B=0x00000001, cin=0 -> bytes 0x00 ×4; cout=1; overflow=0.
- A=0x7FFFFFFF, B=0x00000001 -> bytes 0x00,0x00,0x00,0x80.
  - With SERIAL_ADD_OVF_EN: overflow=1.
  - Without: overflow=0.
- A=B=0, cin=1 -> bytes 0x01,0x00,0x00,0x00; cout=0.
- out_ready held 0 for 3 cycles after the 2nd byte -> in_ready=0, and sum_byte holds its value through all 3 cycles; the sequence completes correctly after release.
- rst_n pulsed low after the 2nd accept -> all outputs return to reset values immediately; the state is IDLE; a fresh start then computes correctly.
